// File: rtl/reset_sequencer.sv
// Releases a chain of downstream block resets one stage at a time once each
// stage reports ready. Define RSTSEQ_TIMEOUT_EN to enable per-stage timeout and the sticky fault.
module reset_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic                pclk,
  input  logic                rst,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                all_ready,
  output logic                fault,
  output logic [2:0]          fault_stage
);

  localparam int MAX_CNT = (HOLD_CYCLES > TIMEOUT) ? HOLD_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(N_STAGES - 1);
`ifdef RSTSEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_WAIT  = 2'd1,
`ifdef RSTSEQ_TIMEOUT_EN
    S_FAULT = 2'd3,
`endif
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2:0]          r_idx;
  logic [N_STAGES-1:0] r_stage_rst;
  logic                r_all_ready;
  logic                w_cur_ready;
  logic                w_drop_wait;
  logic                w_drop_done;

  // Ready of the stage being waited on, and dropouts among already-released stages
  always_comb begin
    w_cur_ready = 1'b0;
    w_drop_wait = 1'b0;
    for (int j = 0; j < N_STAGES; j++) begin
      w_cur_ready = w_cur_ready | ((3'(j) == r_idx) & stage_ready[j]);
      w_drop_wait = w_drop_wait | ((3'(j) < r_idx) & ~stage_ready[j]);
    end
    w_drop_done = ~(&stage_ready);
  end

`ifdef RSTSEQ_TIMEOUT_EN
  logic       r_fault;
  logic [2:0] r_fault_stage;
  assign fault       = r_fault;
  assign fault_stage = r_fault_stage;
`else
  assign fault       = 1'b0;
  assign fault_stage = 3'd0;
`endif

  assign stage_rst = r_stage_rst;
  assign all_ready = r_all_ready;

  // Sequencer FSM; a dropout restart takes priority over advance and timeout
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state       <= S_HOLD;
      r_cnt         <= '0;
      r_idx         <= 3'd0;
      r_stage_rst   <= '1;
      r_all_ready   <= 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
      r_fault       <= 1'b0;
      r_fault_stage <= 3'd0;
`endif
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_state     <= S_WAIT;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_stage_rst <= r_stage_rst << 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WAIT: begin
          if (w_drop_wait) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_stage_rst <= '1;
            r_all_ready <= 1'b0;
          end else if (w_cur_ready) begin
            r_cnt <= '0;
            if (r_idx == LAST_IDX) begin
              r_state     <= S_DONE;
              r_all_ready <= 1'b1;
            end else begin
              r_idx       <= r_idx + 3'd1;
              r_stage_rst <= r_stage_rst << 1'b1;
            end
`ifdef RSTSEQ_TIMEOUT_EN
          end else if (r_cnt == TO_LAST) begin
            r_state       <= S_FAULT;
            r_stage_rst   <= '1;
            r_fault       <= 1'b1;
            r_fault_stage <= r_idx;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`else
          end else begin
            r_cnt <= r_cnt;
          end
`endif
        end
        S_DONE: begin
          if (w_drop_done) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_stage_rst <= '1;
            r_all_ready <= 1'b0;
          end else begin
            r_state <= S_DONE;
          end
        end
`ifdef RSTSEQ_TIMEOUT_EN
        S_FAULT: begin
          r_state <= S_FAULT;
        end
`endif
        default: begin
          r_state     <= S_HOLD;
          r_cnt       <= '0;
          r_idx       <= 3'd0;
          r_stage_rst <= '1;
          r_all_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer (N_STAGES=3, HOLD_CYCLES=16, TIMEOUT=8).
// Expected output-change events are queued up front and compared with the observed changes.
module tb_reset_sequencer;

  logic       pclk;
  logic       rst;
  logic [2:0] stage_ready;
  logic [2:0] stage_rst;
  logic       all_ready;
  logic       fault;
  logic [2:0] fault_stage;

  typedef struct packed {
    logic [31:0] en;
    logic [2:0]  srst;
    logic        ar;
    logic        flt;
    logic [2:0]  fs;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] prev;
  int         edge_n;
  int         checks;
  int         failures;

  reset_sequencer #(.N_STAGES(3), .HOLD_CYCLES(16), .TIMEOUT(8)) dut (
    .pclk(pclk), .rst(rst), .stage_ready(stage_ready), .stage_rst(stage_rst),
    .all_ready(all_ready), .fault(fault), .fault_stage(fault_stage)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic push_exp(input int en, input logic [2:0] s, input logic ar,
                          input logic f, input logic [2:0] fs);
    ev_t e;
    e.en = en; e.srst = s; e.ar = ar; e.flt = f; e.fs = fs;
    exp_q.push_back(e);
  endtask

  // advance one edge, sample #1 later, record any output change
  task automatic step();
    ev_t o;
    @(posedge pclk);
    #1;
    edge_n++;
    if ({stage_rst, all_ready, fault, fault_stage} !== prev) begin
      o.en = edge_n; o.srst = stage_rst; o.ar = all_ready; o.flt = fault; o.fs = fault_stage;
      obs_q.push_back(o);
      prev = {stage_rst, all_ready, fault, fault_stage};
    end
  endtask

  task automatic apply_reset(input logic [2:0] rdy);
    rst = 1'b1;
    stage_ready = rdy;
    repeat (2) @(posedge pclk);
    #1;
    rst = 1'b0;
    edge_n = 0;
    prev = 8'b1110_0000;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stage_ready = 3'b000;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if ({stage_rst, all_ready, fault, fault_stage} !== 8'b1110_0000) begin
      failures++;
      $display("FAIL reset_values actual=%b required=%b",
               {stage_rst, all_ready, fault, fault_stage}, 8'b1110_0000);
    end
  endtask

  task automatic test_happy();
    ev_t e, o;
    apply_reset(3'b000);
    push_exp(16, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(18, 3'b100, 1'b0, 1'b0, 3'd0);
    push_exp(20, 3'b000, 1'b0, 1'b0, 3'd0);
    push_exp(22, 3'b000, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 30; i++) begin
      step();
      if (edge_n == 17) stage_ready[0] = 1'b1;
      if (edge_n == 19) stage_ready[1] = 1'b1;
      if (edge_n == 21) stage_ready[2] = 1'b1;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL happy_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL happy_event actual edge=%0d rst=%b rdy=%b flt=%b fs=%0d required edge=%0d rst=%b rdy=%b flt=%b fs=%0d",
                 o.en, o.srst, o.ar, o.flt, o.fs, e.en, e.srst, e.ar, e.flt, e.fs);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(3'b000);
    for (int i = 0; i < 17; i++) begin
      step();
      if (edge_n == 16) stage_ready[0] = 1'b1;
    end
    checks++;
    if (stage_rst !== 3'b100) begin
      failures++;
      $display("FAIL midwait1_state actual=%b required=%b", stage_rst, 3'b100);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({stage_rst, all_ready, fault} !== 5'b11100) begin
      failures++;
      $display("FAIL async_reset actual=%b required=%b", {stage_rst, all_ready, fault}, 5'b11100);
    end
  endtask

  task automatic test_instant();
    ev_t e, o;
    apply_reset(3'b111);
    push_exp(16, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(17, 3'b100, 1'b0, 1'b0, 3'd0);
    push_exp(18, 3'b000, 1'b0, 1'b0, 3'd0);
    push_exp(19, 3'b000, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 25; i++) step();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL instant_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL instant_event actual edge=%0d rst=%b rdy=%b flt=%b fs=%0d required edge=%0d rst=%b rdy=%b flt=%b fs=%0d",
                 o.en, o.srst, o.ar, o.flt, o.fs, e.en, e.srst, e.ar, e.flt, e.fs);
      end
    end
  endtask

  task automatic test_timeout();
    ev_t e, o;
    apply_reset(3'b001);
    push_exp(16, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(17, 3'b100, 1'b0, 1'b0, 3'd0);
`ifdef RSTSEQ_TIMEOUT_EN
    push_exp(25, 3'b111, 1'b0, 1'b1, 3'd1);
    for (int i = 0; i < 40; i++) step();
`else
    push_exp(61, 3'b000, 1'b0, 1'b0, 3'd0);
    push_exp(62, 3'b000, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 70; i++) begin
      step();
      if (edge_n == 60) stage_ready = 3'b111;
    end
`endif
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL timeout_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL timeout_event actual edge=%0d rst=%b rdy=%b flt=%b fs=%0d required edge=%0d rst=%b rdy=%b flt=%b fs=%0d",
                 o.en, o.srst, o.ar, o.flt, o.fs, e.en, e.srst, e.ar, e.flt, e.fs);
      end
    end
    // ready seen exactly at the last sampled edge must still advance
    apply_reset(3'b001);
    push_exp(16, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(17, 3'b100, 1'b0, 1'b0, 3'd0);
    push_exp(25, 3'b000, 1'b0, 1'b0, 3'd0);
    push_exp(26, 3'b000, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 32; i++) begin
      step();
      if (edge_n == 24) stage_ready = 3'b111;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL late_ready_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL late_ready_event actual edge=%0d rst=%b rdy=%b flt=%b fs=%0d required edge=%0d rst=%b rdy=%b flt=%b fs=%0d",
                 o.en, o.srst, o.ar, o.flt, o.fs, e.en, e.srst, e.ar, e.flt, e.fs);
      end
    end
  endtask

  task automatic test_dropout();
    ev_t e, o;
    apply_reset(3'b111);
    push_exp(16, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(17, 3'b100, 1'b0, 1'b0, 3'd0);
    push_exp(18, 3'b000, 1'b0, 1'b0, 3'd0);
    push_exp(19, 3'b000, 1'b1, 1'b0, 3'd0);
    push_exp(26, 3'b111, 1'b0, 1'b0, 3'd0);
    push_exp(42, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(43, 3'b100, 1'b0, 1'b0, 3'd0);
    push_exp(44, 3'b000, 1'b0, 1'b0, 3'd0);
    push_exp(45, 3'b000, 1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 55; i++) begin
      step();
      if (edge_n == 25) stage_ready = 3'b110;
      if (edge_n == 26) stage_ready = 3'b111;
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL dropout_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL dropout_event actual edge=%0d rst=%b rdy=%b flt=%b fs=%0d required edge=%0d rst=%b rdy=%b flt=%b fs=%0d",
                 o.en, o.srst, o.ar, o.flt, o.fs, e.en, e.srst, e.ar, e.flt, e.fs);
      end
    end
  endtask

  task automatic test_simultaneous();
    ev_t e, o;
    apply_reset(3'b011);
    push_exp(16, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(17, 3'b100, 1'b0, 1'b0, 3'd0);
    push_exp(18, 3'b000, 1'b0, 1'b0, 3'd0);
    push_exp(21, 3'b111, 1'b0, 1'b0, 3'd0);
    push_exp(37, 3'b110, 1'b0, 1'b0, 3'd0);
    push_exp(38, 3'b100, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 45; i++) begin
      step();
      if (edge_n == 20) stage_ready = 3'b101;
      if (edge_n == 21) begin
        checks++;
        if (all_ready !== 1'b0) begin
          failures++;
          $display("FAIL simul_all_ready actual=%b required=%b", all_ready, 1'b0);
        end
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL simul_count actual=%0d required=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL simul_event actual edge=%0d rst=%b rdy=%b flt=%b fs=%0d required edge=%0d rst=%b rdy=%b flt=%b fs=%0d",
                 o.en, o.srst, o.ar, o.flt, o.fs, e.en, e.srst, e.ar, e.flt, e.fs);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    edge_n = 0;
    prev = 8'b1110_0000;
    rst = 1'b1;
    stage_ready = 3'b000;
    test_reset();
    test_happy();
    test_reset_mid();
    test_instant();
    test_timeout();
    test_dropout();
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Consumer-side partner of the board reset generator. It takes the single delayed system reset and releases a chain of downstream block resets one at a time. Each stage (e.g. VGA timing, mouse controller, game logic) must report ready before the next stage is released. The final result is one `all_ready` flag for the top level, plus an optional timeout fault.

## Interface
Parameters:
- `N_STAGES`, default 3: number of sequenced downstream resets (1..8).
- `HOLD_CYCLES`, default 16: cycles all stage resets are held after `rst` deasserts (≥1).
- `TIMEOUT`, default 1024: max cycles allowed for a stage to report ready (≥1).

Ports:
- `pclk`, input, 1: system clock; every register is clocked on its rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `stage_ready`, input, N_STAGES: per-stage ready, synchronous to `pclk`; bit i belongs to stage i.
- `stage_rst`, output, N_STAGES: per-stage reset, active-high, registered.
- `all_ready`, output, 1: high while every stage is released and ready.
- `fault`, output, 1: sticky timeout fault.
- `fault_stage`, output, 3: index of the stage that timed out.

## Operation
Reset values while `rst`=1:
- `stage_rst` = all ones.
- `all_ready`=0, `fault`=0, `fault_stage`=0.
- State HOLD, counter=0.

States:
- **HOLD**
  - Counter increments each cycle.
  - On the edge where counter reaches HOLD_CYCLES-1, go to WAIT(0) and clear `stage_rst[0]`.
- **WAIT(i)**
  - `stage_rst[i:0]` are 0; higher bits stay 1.
  - Counter restarts at 0 on entry and increments each cycle.
  - `stage_ready[i]` sampled high: if i<N_STAGES-1, clear `stage_rst[i+1]` and go to WAIT(i+1); otherwise set `all_ready` and go to DONE.
- **DONE**
  - Holding state; outputs stable.
- **FAULT**
  - `stage_rst` all ones, `all_ready`=0, `fault`=1.
  - Exit only via `rst`.

Restart rule:
- In WAIT(i) or DONE, if any `stage_ready[j]` for an already-released stage drops to 0, re-assert all `stage_rst` and clear `all_ready` on that edge.
- Return to HOLD with counter=0.
- In WAIT(i), the check applies to j<i; in DONE, to all j.

Other rules:
- `stage_ready` of unreleased stages is ignored.
- If restart and advance conditions occur on the same edge, restart wins.
- Reset mid-sequence: immediate asynchronous return to the reset values, whatever the state.

## Timing
- Edge 1 is the first rising edge with `rst`=0.
- `stage_rst[0]` falls at edge HOLD_CYCLES.
- Stage i is released at edge R. Its ready is sampled at edges R+1 through R+TIMEOUT.
- Ready first seen high at edge R+k: the next stage's `stage_rst` falls at that same edge (registered, one cycle after ready is visible). For the last stage, `all_ready` rises at that edge.
- Minimum total release time: HOLD_CYCLES + N_STAGES - 1 edges to the last release, then +1 edge to `all_ready`.
- Timeout: `stage_ready[i]`=0 at edge R+TIMEOUT. At that edge `fault`=1, `fault_stage`=i, all `stage_rst`=1.
- Counter width is $clog2(max(HOLD_CYCLES,TIMEOUT))+1 bits and must never wrap.

## Configuration
- Macro `RSTSEQ_TIMEOUT_EN`.
- Defined: timeout detection and the FAULT state work as described above.
- Undefined:
  - WAIT(i) waits forever; the counter is not used in WAIT.
  - `fault` and `fault_stage` are tied to 0.
  - FAULT state does not exist.
  - HOLD and restart behaviour are unchanged.

## Test plan
All scenarios use N_STAGES=3, HOLD_CYCLES=16, TIMEOUT=8.
1. Reset: `rst` high mid-WAIT(1) -> `stage_rst`=3'b111, `all_ready`=0 asynchronously (before the next edge).
2. Happy path: release `rst`; each stage raises ready 2 edges after its release -> `stage_rst[0]` falls at edge 16, bit 1 at edge 18, bit 2 at edge 20, `all_ready` rises at edge 22.
3. Instant ready: `stage_ready` tied to 3'b111 -> bits fall at edges 16, 17, 18; `all_ready` rises at edge 19.
4. Timeout (macro defined): stage 1 never ready -> at edge 17+8=25, `fault`=1, `fault_stage`=1, `stage_rst`=3'b111, state stays FAULT until `rst`. With the macro undefined -> no fault; the sequencer stays in WAIT(1) indefinitely, then completes when ready finally rises.
5. Dropout in DONE: `stage_ready[0]` pulses low one cycle -> `stage_rst`=3'b111 and `all_ready`=0 at that edge; full sequence repeats, `all_ready` again after 16+ edges.
6. Simultaneous events: in WAIT(2), `stage_ready[2]` rises on the same edge `stage_ready[1]` drops -> restart wins, `all_ready` stays 0.
